complex_gates_arbiter: RTL
==========================

# complex_gates_arbiter

Sequencer and round-robin arbiter that shares one combinational `complex_gates` evaluator (8-bit `x`, 8-bit `y`, 1-bit `out`) between two requesters. It latches the winning requester's operands into registers that drive the evaluator, samples the evaluator output one cycle later, and returns the result with a done pulse to the requester that was granted. It sits between the requester logic and a single `complex_gates` instance at the same level of hierarchy.

## Interface
Parameters:
- `W`, 8, operand width; must match the `complex_gates` inputs.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  request level from requester 0/1.
- `x0`, `y0`, `x1`, `y1`  in  W  operands; sampled only in the grant cycle.
- `gnt0`, `gnt1`  out  1  one-cycle pulse: request accepted, operands captured.
- `done0`, `done1`  out  1  one-cycle pulse: `result` valid for that requester.
- `result`  out  1  registered evaluator output; holds until the next capture.
- `busy`  out  1  high in DRIVE and CAPTURE.
- `dut_x`, `dut_y`  out  W  registered operands to the `complex_gates` `x`/`y`.
- `dut_out`  in  1  `complex_gates` `out`; combinational from `dut_x`/`dut_y`.
- `cnt0`, `cnt1`  out  16  completed-operation counters (only with `CGA_STATS_EN`).

## Operation
- FSM states:
  - IDLE: if any `req` is high, arbitrate, pulse the winner's `gnt`, load `dut_x`/`dut_y` from the winner's operands, record `owner`, and go to DRIVE.
  - DRIVE: the evaluator settles. Go to CAPTURE unconditionally.
  - CAPTURE: `result <= dut_out`, pulse `done[owner]`, return to IDLE.
- Arbitration is round-robin on `last`, which is updated at grant.
  - If both requests are high, grant the requester that is not `last`.
  - If only one request is high, grant it regardless of `last`.
- `req` is a level. A requester deasserts it on the cycle after `gnt`. A `req` still high when the FSM re-enters IDLE counts as a new request.
- Requests are ignored while `busy`. No queueing and no grant while busy.
- `dut_x`/`dut_y` hold their values after CAPTURE until the next grant.
- Operands are captured exactly once, in the grant cycle. Changes afterwards do not affect the result.
- Reset values: `dut_x`=0, `dut_y`=0, `result`=0, all `gnt`/`done`=0, `busy`=0, state=IDLE, `last`=1 (requester 0 wins the first tie), `owner`=0, counters=0.
- Reset asserted mid-operation aborts the operation. No `done` is issued and the next cycle is IDLE with reset values.

## Timing
- Grant at edge T (IDLE, `gnt` high during the cycle after T). Then DRIVE at T+1, CAPTURE at T+2, and `done` and `result` are visible after edge T+2.
- Latency from the grant cycle to the done cycle is 2 clocks.
- Minimum spacing between grants is 3 clocks. With both requesters continuously requesting, grants alternate 0,1,0,1.
- `gnt0`/`gnt1` are mutually exclusive. `done0`/`done1` are mutually exclusive. `gnt` and `done` are never high in the same cycle.

## Configuration
- `CGA_STATS_EN` defined: `cnt0`/`cnt1` exist. Each increments by 1 in the cycle its `done` fires and saturates at 16'hFFFF. Each resets to 0.
- `CGA_STATS_EN` undefined: ports and counter logic are absent, and all other behaviour is identical.

## Structure
- Package `complex_gates_arbiter_pkg` holds:
  - state typedef with encodings IDLE=2'd0, DRIVE=2'd1, CAPTURE=2'd2;
  - the `W` default;
  - the counter width constant (16).
- Sub-module `rr_arb2`: a combinational 2-way round-robin picker. Inputs are `req[1:0]` and `last`. Outputs are a one-hot `grant[1:0]` and `any`.
- The top instantiates `rr_arb2` and the FSM. `complex_gates` is instantiated by the parent or the bench, not inside this block.

## Test plan
The bench instantiates the real `complex_gates`.
- After reset, check all outputs are 0 and `busy`=0. Pulse `req0` with x0=8'b01100111, y0=8'b00011011. Expect `gnt0` one cycle, `done0` 2 cycles later, and `result`=0.
- Pulse `req1` with x1=8'b01100111, y1=8'b00011111. Expect `gnt1`, then `done1` with `result`=1. `dut_x`/`dut_y` then hold these operands.
- Raise `req0` and `req1` in the same cycle from reset. Expect `gnt0` first and `gnt1` 3 cycles later. Hold both high for 6 operations and expect grants alternating 0,1,0,1,0,1.
- Change x0 from 8'b11100101 to 8'b11100100 in the cycle after `gnt0`, with y0=8'b00011111. Expect `result`=1 (the captured operand is used).
- Assert `rst` during DRIVE. Expect no `done`, state IDLE, and all outputs 0. A `req0` issued afterwards completes normally.
- With `CGA_STATS_EN` defined: after 3 ops on requester 0 and 2 ops on requester 1, expect `cnt0`=3 and `cnt1`=2. Force the counter to 16'hFFFE, complete 2 more ops, and expect it to stay at 16'hFFFF.

Source files
------------

// File: rtl/complex_gates_arbiter_pkg.sv
// Shared types and constants for the complex_gates sequencer/arbiter.
// Optional completion counters are enabled with CGA_STATS_EN.
package complex_gates_arbiter_pkg;

    localparam int unsigned CGA_W = 8;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    // Saturating increment for the completion counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/complex_gates_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; last=1 favours requester 0.
// Grant is one-hot when any request is present, else zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       any
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/complex_gates_arbiter.sv
// Round-robin sequencer sharing one complex_gates evaluator between two
// requesters. Define CGA_STATS_EN to add per-requester completion counters.
module complex_gates_arbiter
    import complex_gates_arbiter_pkg::*;
#(
    parameter int unsigned W = CGA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         result,
    output logic         busy,
    output logic [W-1:0] dut_x,
    output logic [W-1:0] dut_y,
    input  logic         dut_out
`ifdef CGA_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic           owner_q, owner_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic           result_q, result_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [1:0]     done_q, done_d;

    logic [1:0]     arb_grant;
    logic           arb_any;

    rr_arb2 u_arb (
        .req   ({req1, req0}),
        .last  (last_q),
        .grant (arb_grant),
        .any   (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d   = arb_grant;
                    owner_d = arb_grant[1];
                    last_d  = arb_grant[1];
                    x_d     = arb_grant[1] ? x1 : x0;
                    y_d     = arb_grant[1] ? y1 : y0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                result_d = dut_out;
                done_d   = owner_q ? 2'b10 : 2'b01;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= 1'b0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
        end
    end

    assign gnt0   = gnt_q[0];
    assign gnt1   = gnt_q[1];
    assign done0  = done_q[0];
    assign done1  = done_q[1];
    assign result = result_q;
    assign busy   = (state_q != IDLE);
    assign dut_x  = x_q;
    assign dut_y  = y_q;

`ifdef CGA_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Counters step together with the done pulse they account for.
    always_comb begin
        cnt0_d = done_d[0] ? sat_inc(cnt0_q) : cnt0_q;
        cnt1_d = done_d[1] ? sat_inc(cnt1_q) : cnt1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule
